// File: rtl/arr4x4_sched_if.sv
// rtl/arr4x4_sched_if.sv - Port bundle of the 4x4 array operand scheduler
// Error-mask write port exists only with ARR4X4_SCHED_ERRINJ_EN.
interface arr4x4_sched_if #(parameter int LEN_W = 8) ();
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_w;
  logic [31:0]      in_a;
  logic [7:0]       w1_in, w2_in, w3_in, w4_in;
  logic [7:0]       a1_in, a2_in, a3_in, a4_in;
  logic [23:0]      c1_out, c2_out, c3_out, c4_out;
  logic             hold;
  logic             out_valid;
  logic             out_ready;
  logic [95:0]      out_c;
  logic [15:0]      Err_mac;
  logic [15:0]      Err_mult;
`ifdef ARR4X4_SCHED_ERRINJ_EN
  logic             err_we;
  logic             err_sel;
  logic [15:0]      err_data;
`endif

  modport slave (
`ifdef ARR4X4_SCHED_ERRINJ_EN
    input  err_we, input err_sel, input err_data,
`endif
    input  start, frame_len, in_valid, in_w, in_a, c1_out, c2_out, c3_out, c4_out, out_ready,
    output busy, done, in_ready, w1_in, w2_in, w3_in, w4_in, a1_in, a2_in, a3_in, a4_in,
    output hold, out_valid, out_c, Err_mac, Err_mult
  );

  modport master (
`ifdef ARR4X4_SCHED_ERRINJ_EN
    output err_we, output err_sel, output err_data,
`endif
    output start, frame_len, in_valid, in_w, in_a, c1_out, c2_out, c3_out, c4_out, out_ready,
    input  busy, done, in_ready, w1_in, w2_in, w3_in, w4_in, a1_in, a2_in, a3_in, a4_in,
    input  hold, out_valid, out_c, Err_mac, Err_mult
  );
endinterface

// File: rtl/arr4x4_sched.sv
// rtl/arr4x4_sched.sv - Skew/deskew operand scheduler and frame sequencer for the 4x4 PE array
// Optional fault-inject mask registers: ARR4X4_SCHED_ERRINJ_EN.
module arr4x4_sched #(
  parameter int CAP_LAT = 4,
  parameter int LEN_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  arr4x4_sched_if.slave bus_io
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int         NT      = CAP_LAT + 4;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [NT-1:0]    tag_q;
  logic             out_valid_q;
  logic [95:0]      out_c_q;
  logic             hold, accept, done;
  logic [7:0]       w_feed [4];
  logic [7:0]       a_feed [4];
  logic [23:0]      c_in   [4];
  logic [23:0]      row_al [4];

  assign hold   = out_valid_q && !bus_io.out_ready;
  assign accept = bus_io.in_valid && bus_io.in_ready;
  // Last result leaves once nothing tagged remains in flight; no new beats enter in DRAIN.
  assign done   = (state_q == S_DRAIN) && out_valid_q && bus_io.out_ready && (tag_q == '0);

  assign bus_io.busy      = (state_q != S_IDLE);
  assign bus_io.in_ready  = (state_q == S_RUN) && !hold;
  assign bus_io.done      = done;
  assign bus_io.hold      = hold;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_c     = out_c_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus_io.start) begin
          state_d = S_RUN;
          cnt_d   = (bus_io.frame_len == '0) ? LEN_W'(1) : bus_io.frame_len;
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= {tag_q[NT-2:0], accept};
    end
  end

  // Lane g carries row g+1 weight and column g+1 activation, both delayed g cycles.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] w_sk_q [gi+1];
    logic [7:0] a_sk_q [gi+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= gi; k++) begin
          w_sk_q[k] <= '0;
          a_sk_q[k] <= '0;
        end
      end else if (!hold) begin
        w_sk_q[0] <= accept ? bus_io.in_w[8*gi +: 8] : 8'h00;
        a_sk_q[0] <= accept ? bus_io.in_a[8*gi +: 8] : 8'h00;
        for (int k = 1; k <= gi; k++) begin
          w_sk_q[k] <= w_sk_q[k-1];
          a_sk_q[k] <= a_sk_q[k-1];
        end
      end
    end

    assign w_feed[gi] = w_sk_q[gi];
    assign a_feed[gi] = a_sk_q[gi];
  end

  assign bus_io.w1_in = w_feed[0];
  assign bus_io.w2_in = w_feed[1];
  assign bus_io.w3_in = w_feed[2];
  assign bus_io.w4_in = w_feed[3];
  assign bus_io.a1_in = a_feed[0];
  assign bus_io.a2_in = a_feed[1];
  assign bus_io.a3_in = a_feed[2];
  assign bus_io.a4_in = a_feed[3];

  assign c_in[0] = bus_io.c1_out;
  assign c_in[1] = bus_io.c2_out;
  assign c_in[2] = bus_io.c3_out;
  assign c_in[3] = bus_io.c4_out;

  // Rows 1..3 are captured on their own tag and shifted until row 4 catches up.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dsk
    logic [23:0] dk_q [3-gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < 3 - gi; k++) dk_q[k] <= '0;
      end else if (!hold) begin
        if (tag_q[gi+CAP_LAT]) dk_q[0] <= c_in[gi];
        for (int k = 1; k < 3 - gi; k++) dk_q[k] <= dk_q[k-1];
      end
    end

    assign row_al[gi] = dk_q[2-gi];
  end

  assign row_al[3] = c_in[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
    end else if (!hold) begin
      out_valid_q <= tag_q[NT-1];
      if (tag_q[NT-1]) out_c_q <= {row_al[3], row_al[2], row_al[1], row_al[0]};
    end
  end

`ifdef ARR4X4_SCHED_ERRINJ_EN
  logic [15:0] err_mac_q, err_mult_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_mac_q  <= '0;
      err_mult_q <= '0;
    end else if (bus_io.err_we) begin
      if (bus_io.err_sel) err_mult_q <= bus_io.err_data;
      else                err_mac_q  <= bus_io.err_data;
    end
  end

  assign bus_io.Err_mac  = err_mac_q;
  assign bus_io.Err_mult = err_mult_q;
`else
  assign bus_io.Err_mac  = 16'h0000;
  assign bus_io.Err_mult = 16'h0000;
`endif

endmodule

// File: tb/tb_arr4x4_sched.sv
// tb/tb_arr4x4_sched.sv - Scoreboard bench for arr4x4_sched with a behavioural 4x4 systolic array
module tb_arr4x4_sched;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arr4x4_sched_if #(.LEN_W(8)) bus ();

  arr4x4_sched #(.CAP_LAT(4), .LEN_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Systolic array stand-in: weights move right, activations move down, partial sums move right.
  logic [7:0]         wf [4];
  logic [7:0]         af [4];
  logic signed [7:0]  mw [4][4];
  logic signed [7:0]  ma [4][4];
  logic signed [23:0] mp [4][4];
  logic signed [7:0]  wv, av;
  logic signed [23:0] pv;
  logic signed [15:0] pr;

  assign wf = '{bus.w1_in, bus.w2_in, bus.w3_in, bus.w4_in};
  assign af = '{bus.a1_in, bus.a2_in, bus.a3_in, bus.a4_in};
  assign bus.c1_out = mp[0][3];
  assign bus.c2_out = mp[1][3];
  assign bus.c3_out = mp[2][3];
  assign bus.c4_out = mp[3][3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (rst) begin
          mw[i][j] <= '0;
          ma[i][j] <= '0;
          mp[i][j] <= '0;
        end else if (!bus.hold) begin
          wv = (j == 0) ? wf[i] : mw[i][j-1];
          av = (i == 0) ? af[j] : ma[i-1][j];
          pv = (j == 0) ? 24'sd0 : mp[i][j-1];
          pr = wv * av;
          mw[i][j] <= wv;
          ma[i][j] <= av;
          mp[i][j] <= pv + {{8{pr[15]}}, pr};
        end
      end
    end
  end

  function automatic logic [95:0] golden(input logic [31:0] w, input logic [31:0] a);
    logic [95:0]        r;
    logic signed [23:0] s;
    logic signed [15:0] p;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = '0;
      for (int j = 0; j < 4; j++) begin
        p = $signed(w[8*i +: 8]) * $signed(a[8*j +: 8]);
        s = s + {{8{p[15]}}, p};
      end
      r[24*i +: 24] = s;
    end
    return r;
  endfunction

  typedef struct {
    logic [95:0] c;
    int          cyc;
    int          hc;
    bit          last;
  } exp_t;

  exp_t        sb [$];
  int          hs_log [$];
  int          n_acc = 0, n_res = 0, n_done = 0, hc = 0;
  int          first_cyc = 0, first_hc = 0;
  bit          prev_ov = 0, prev_hs = 0;
  logic [95:0] last_c = '0;
  int          frame_base = 0, eff_len = 1;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_ov = 0;
      prev_hs = 0;
    end else begin
      if (bus.out_valid && (!prev_ov || prev_hs)) begin
        first_cyc = cyc;
        first_hc  = hc;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("result_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_c", bus.out_c, e.c);
          chk("latency", first_cyc - e.cyc, 9 + first_hc - e.hc);
          chk("done_last", bus.done, e.last);
        end
        last_c = bus.out_c;
        hs_log.push_back(cyc);
        n_res++;
        if (bus.done) n_done++;
      end else begin
        chk("done_idle", bus.done, 1'b0);
      end
      if (bus.hold) chk("in_ready_in_hold", bus.in_ready, 1'b0);
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back('{golden(bus.in_w, bus.in_a), cyc, hc, (n_acc - frame_base + 1) == eff_len});
        n_acc++;
      end
      if (bus.hold) hc++;
      prev_ov = bus.out_valid;
      prev_hs = bus.out_valid && bus.out_ready;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_hold"}, bus.hold, 1'b0);
    chk({tag, "_feeds"}, {bus.w1_in, bus.w2_in, bus.w3_in, bus.w4_in,
                          bus.a1_in, bus.a2_in, bus.a3_in, bus.a4_in}, '0);
    chk({tag, "_out_c"}, bus.out_c, '0);
    chk({tag, "_err"}, {bus.Err_mac, bus.Err_mult}, '0);
  endtask

  task automatic start_frame(input int len);
    bus.start     = 1'b1;
    bus.frame_len = 8'(len);
    eff_len       = (len == 0) ? 1 : len;
    frame_base    = n_acc;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] w, input logic [31:0] a);
    bit ok;
    int guard;
    ok          = 0;
    guard       = 0;
    bus.in_valid = 1'b1;
    bus.in_w     = w;
    bus.in_a     = a;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) chk("in_ready_wait", ok, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int g = 0; g < 400 && n_done == d0; g++) begin
      @(negedge clk); #1;
    end
    chk("done_seen", n_done - d0, 1);
  endtask

  task automatic run_frame(input int len, input bit gap, input bit poke);
    int d0;
    d0 = n_done;
    start_frame(len);
    for (int k = 0; k < eff_len; k++) begin
      if (poke && k == 5) begin
        bus.start     = 1'b1;
        bus.frame_len = 8'd3;
      end
      send_beat($urandom, $urandom);
      bus.start = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
    wait_done(d0);
    @(posedge clk); #1;
  endtask

  task automatic stall_third(input int r0);
    for (int g = 0; g < 400 && (n_res - r0) < 2; g++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
  endtask

  int r0, hc0, d0;

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.frame_len = '0;
    bus.in_valid  = 1'b0;
    bus.in_w      = '0;
    bus.in_a      = '0;
    bus.out_ready = 1'b1;
`ifdef ARR4X4_SCHED_ERRINJ_EN
    bus.err_we   = 1'b0;
    bus.err_sel  = 1'b0;
    bus.err_data = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    d0 = n_done;
    start_frame(1);
    send_beat(32'h04030201, 32'h01010101);
    @(negedge clk);
    chk("w1_at_t1", bus.w1_in, 8'd1);
    chk("w2_at_t1", bus.w2_in, 8'd0);
    repeat (3) @(negedge clk);
    chk("w4_at_t4", bus.w4_in, 8'd4);
    wait_done(d0);
    chk("single_c", last_c, 96'h000010_00000c_000008_000004);
    chk("busy_at_done", bus.busy, 1'b1);
    @(negedge clk);
    chk("busy_fall", bus.busy, 1'b0);
    @(posedge clk); #1;

    r0 = n_res;
    run_frame(0, 0, 0);
    chk("len0_count", n_res - r0, 1);

    r0  = n_res;
    hc0 = hc;
    run_frame(16, 0, 1);
    chk("stream_count", n_res - r0, 16);
    chk("stream_hold", hc - hc0, 0);
    chk("stream_span", hs_log[r0 + 15] - hs_log[r0], 15);

    r0  = n_res;
    hc0 = hc;
    fork
      run_frame(12, 0, 0);
      stall_third(r0);
    join
    chk("bp_count", n_res - r0, 12);
    chk("bp_hold_cycles", hc - hc0, 5);
    chk("bp_sb_empty", sb.size(), 0);

    r0 = n_res;
    run_frame(4, 1, 0);
    chk("bubble_count", n_res - r0, 4);

    d0 = n_done;
    start_frame(8);
    repeat (3) send_beat($urandom, $urandom);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("rst_no_done", n_done - d0, 0);
    chk("rst_sb_empty", sb.size(), 0);

    r0 = n_res;
    run_frame(4, 0, 0);
    chk("fresh_count", n_res - r0, 4);

`ifdef ARR4X4_SCHED_ERRINJ_EN
    bus.err_we   = 1'b1;
    bus.err_sel  = 1'b0;
    bus.err_data = 16'h8001;
    @(posedge clk); #1;
    bus.err_we   = 1'b0;
    @(negedge clk);
    chk("err_mac", bus.Err_mac, 16'h8001);
    chk("err_mult", bus.Err_mult, 16'h0000);
`else
    @(negedge clk);
    chk("err_mac_tied", bus.Err_mac, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
